mux4_1_reg: RTL and testbench
=============================

Name: mux4_1_reg

Overview:
- Registered 4-to-1 multiplexer with a WIDTH-bit data path.
- Selects one of four input words (i0..i3) with a 2-bit select and presents it on a registered output, one clock after a valid input.
- Generic datapath selection element. Sits between producer logic and any consumer that needs a clean, glitch-free, registered selection.

Parameters:
- WIDTH, 1, bit width of each data input and of the output.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies i0..i3 and sel in the current cycle.
- i0  input  WIDTH  data input, selected when sel=2'b00.
- i1  input  WIDTH  data input, selected when sel=2'b01.
- i2  input  WIDTH  data input, selected when sel=2'b10.
- i3  input  WIDTH  data input, selected when sel=2'b11.
- sel  input  2  select code.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  high for one cycle per accepted input.
- sel_changed  output  1  one-cycle pulse: accepted sel differs from the previous accepted sel.

Behaviour:
- All state updates on the rising clk edge. No combinational path from any input to any output.
- Reset (rst=1 at a clk edge):
  - out = 0, out_valid = 0, sel_changed = 0.
  - Internal last-sel register = 2'b00.
  - Reset has priority over in_valid in the same cycle.
  - Reset asserted mid-stream discards any in-flight data. First output after reset deasserts is the next accepted input.
- Accept: in_valid=1 and rst=0 at an edge. Next cycle:
  - out = selected word (00->i0, 01->i1, 10->i2, 11->i3).
  - out_valid = 1.
- Latency: exactly 1 cycle from accept to out/out_valid. Throughput: one word per cycle. Back-to-back accepts give back-to-back results.
- in_valid=0: out holds its last value; out_valid = 0; sel_changed = 0.
- sel_changed = 1 in the output cycle of an accepted sel that differs from the last-sel register. Last-sel updates only on accept.
  - First accept after reset compares against 2'b00, so sel=00 gives sel_changed=0.
- sel containing X/Z is out of contract. The case decode uses a default arm that drives i0 so synthesis holds no latch.
- Inputs are sampled only at the edge; changes on non-selected inputs never affect out.

Optional Feature:
- Macro: MUX4_1_REG_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduction of the registered out (even parity).
  - Registered in the same cycle as out; reset value 0; holds with out.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset with in_valid held at 1 -> out=0, out_valid=0, sel_changed=0 on every reset cycle.
2. WIDTH=1 sweep, one accept per cycle, {i0,i1,i2,i3} each shown as a 4-bit pattern:
   - 0000 with sel=00 -> out=0, sel_changed=0.
   - 0100 with sel=01 -> out=1 (i1), sel_changed=1.
   - 0010 with sel=10 -> out=1 (i2), sel_changed=1.
   - 0001 with sel=11 -> out=1 (i3), sel_changed=1.
   - All results appear one cycle after their accept, with out_valid=1.
3. Isolation: WIDTH=8, i0=8'hA5, sel=00, toggle i1..i3 randomly over 10 accepts -> out=8'hA5 every output cycle, sel_changed=0.
4. Hold: accept i2=8'h3C with sel=10, then in_valid=0 for 5 cycles while changing all inputs -> out stays 8'h3C, out_valid=0.
5. Reset mid-stream: accept i3=8'hFF with sel=11, assert rst on the next edge -> out=0, out_valid=0. Next accept with sel=00 gives sel_changed=0.
6. With MUX4_1_REG_PARITY_EN defined, WIDTH=8:
   - Select 8'h07 -> out_parity=1.
   - Select 8'h03 -> out_parity=0.

Source files
------------

// File: rtl/mux4_1_reg.sv
// Registered 4-to-1 multiplexer with valid qualification and a select-change pulse.
// Optional even-parity output enabled by defining MUX4_1_REG_PARITY_EN.
module mux4_1_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_changed
`ifdef MUX4_1_REG_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_changed_q, sel_changed_d;
    logic [1:0]       last_sel_q, last_sel_d;
    logic [WIDTH-1:0] sel_word;

    always_comb begin
        sel_word = i0;
        case (sel)
            2'b00:   sel_word = i0;
            2'b01:   sel_word = i1;
            2'b10:   sel_word = i2;
            2'b11:   sel_word = i3;
            default: sel_word = i0;
        endcase
    end

    // Output word and last-sel only move on an accepted input; otherwise they hold.
    always_comb begin
        out_d         = out_q;
        out_valid_d   = 1'b0;
        sel_changed_d = 1'b0;
        last_sel_d    = last_sel_q;
        if (in_valid) begin
            out_d         = sel_word;
            out_valid_d   = 1'b1;
            sel_changed_d = (sel != last_sel_q);
            last_sel_d    = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            sel_changed_q <= 1'b0;
            last_sel_q    <= 2'b00;
        end else begin
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            sel_changed_q <= sel_changed_d;
            last_sel_q    <= last_sel_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign sel_changed = sel_changed_q;

`ifdef MUX4_1_REG_PARITY_EN
    logic out_parity_q, out_parity_d;

    always_comb begin
        out_parity_d = ^out_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux4_1_reg.sv
// Scoreboard bench for mux4_1_reg (WIDTH=8): driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_mux4_1_reg;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b1;
    logic [W-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] out;
    logic         out_valid;
    logic         sel_changed;
`ifdef MUX4_1_REG_PARITY_EN
    logic         out_parity;
`endif

    mux4_1_reg #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .i0          (i0),
        .i1          (i1),
        .i2          (i2),
        .i3          (i3),
        .sel         (sel),
        .out         (out),
        .out_valid   (out_valid),
        .sel_changed (sel_changed)
`ifdef MUX4_1_REG_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         chg;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [1:0]   m_last_sel = 2'b00;
    logic [W-1:0] exp_hold = '0;
    logic         rst_edge = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the chosen word is simply element sel of the four inputs.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] d, input logic [1:0] s);
        logic [W-1:0] words [4];
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; i0 = a; i1 = b; i2 = c; i3 = d; sel = s;
        words[0] = a; words[1] = b; words[2] = c; words[3] = d;
        if (r) begin
            m_last_sel = 2'b00;
        end else if (v) begin
            e.d   = words[s];
            e.chg = (s != m_last_sel);
            sb.push_back(e);
            m_last_sel = s;
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            check("reset_out", 32'(out), 32'(0));
            check("reset_valid", 32'(out_valid), 32'(0));
            check("reset_selchg", 32'(sel_changed), 32'(0));
`ifdef MUX4_1_REG_PARITY_EN
            check("reset_parity", 32'(out_parity), 32'(0));
`endif
            exp_hold = '0;
        end else if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("data", 32'(out), 32'(e.d));
                check("sel_changed", 32'(sel_changed), 32'(e.chg));
`ifdef MUX4_1_REG_PARITY_EN
                check("parity", 32'(out_parity), 32'(^e.d));
`endif
                exp_hold = e.d;
            end
        end else begin
            check("valid_low", 32'(out_valid), 32'(0));
            check("hold_out", 32'(out), 32'(exp_hold));
            check("idle_selchg", 32'(sel_changed), 32'(0));
`ifdef MUX4_1_REG_PARITY_EN
            check("hold_parity", 32'(out_parity), 32'(^exp_hold));
`endif
        end
    end

    initial begin
        // reset with in_valid held high
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rnd(), rnd(), rnd(), rnd(), 2'(i));
        // single-bit sweep: {i0,i1,i2,i3} = 0000, 0100, 0010, 0001
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        drive(1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 2'b01);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h00, 2'b10);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 2'b11);
        // isolation from non-selected inputs
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'hA5, rnd(), rnd(), rnd(), 2'b00);
        // hold while idle
        drive(1'b0, 1'b1, rnd(), rnd(), 8'h3C, rnd(), 2'b10);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, rnd(), rnd(), rnd(), rnd(), 2'($urandom));
        // reset mid-stream, then sel=00 must not flag a change
        drive(1'b0, 1'b1, rnd(), rnd(), rnd(), 8'hFF, 2'b11);
        drive(1'b1, 1'b1, rnd(), rnd(), rnd(), rnd(), 2'b01);
        drive(1'b0, 1'b1, 8'h5A, rnd(), rnd(), rnd(), 2'b00);
        // parity corner words
        drive(1'b0, 1'b1, rnd(), 8'h07, rnd(), rnd(), 2'b01);
        drive(1'b0, 1'b1, rnd(), rnd(), 8'h03, rnd(), 2'b10);
        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
                  rnd(), rnd(), rnd(), rnd(), 2'($urandom));
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0, 2'b00);
        drive(1'b0, 1'b0, '0, '0, '0, '0, 2'b00);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
